// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings, the
// FSM state encoding and the alignment check used by the top level.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE    = 2'd0,
      SZ_HALF    = 2'd1,
      SZ_WORD    = 2'd2,
      SZ_ILLEGAL = 2'd3
   } lsu_size_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } lsu_state_e;

   // True when the access cannot be served for this size/lane combination.
   // The illegal size encoding is always rejected.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
// Ports:
//   size        - access size (lsu_size_e encoding)
//   is_unsigned - zero-extend sub-word loads when 1, sign-extend when 0
//   lane        - byte offset inside the 32-bit word
//   rword       - raw memory word being loaded from
//   wdata       - right-aligned store data
//   rdata       - extracted and extended load data
//   byte_en     - per-byte write enables for a store
//   wdata_lane  - store data replicated onto every lane it could land in
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [1:0]  lane,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [3:0]  byte_en,
   output logic [31:0] wdata_lane
);

   logic [31:0] shifted_s;

   // Extract/extend the addressed lane and build byte enables for stores
   always_comb begin
      shifted_s  = rword >> {lane, 3'b000};
      rdata      = 32'd0;
      byte_en    = 4'b0000;
      wdata_lane = 32'd0;
      case (size)
         SZ_BYTE: begin
            rdata      = {{24{~is_unsigned & shifted_s[7]}}, shifted_s[7:0]};
            byte_en    = 4'b0001 << lane;
            wdata_lane = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            rdata      = {{16{~is_unsigned & shifted_s[15]}}, shifted_s[15:0]};
            byte_en    = 4'b0011 << lane;
            wdata_lane = {2{wdata[15:0]}};
         end
         SZ_WORD: begin
            rdata      = rword;
            byte_en    = 4'b1111;
            wdata_lane = wdata;
         end
         default: begin
            rdata      = 32'd0;
            byte_en    = 4'b0000;
            wdata_lane = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a DEPTH x 32-bit
// little-endian data array. One request is accepted in IDLE, waits LATENCY
// cycles, and completes with a one-cycle response in RESP.
// Ports:
//   clock, reset (async, active-low)
//   req_valid/req_ready         - request handshake, ready only in IDLE
//   req_write, req_size, req_unsigned, req_addr, req_wdata - request fields
//   resp_valid                  - one-cycle completion pulse
//   resp_rdata, resp_error      - load result / rejection, zero outside RESP
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   localparam int         AW       = $clog2(DEPTH);
   localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

   logic [31:0] memory [DEPTH];

   lsu_state_e  state_r, state_nx_s;
   logic [2:0]  cnt_r, cnt_nx_s;
   logic        write_r, unsigned_r;
   logic [1:0]  size_r;
   logic [31:0] addr_r, wdata_r;
   logic [31:0] resp_rdata_r;
   logic        resp_error_r;

   logic        accept_s, enter_resp_s, err_s, mem_we_s;
   logic        acc_write_s, acc_unsigned_s;
   logic [1:0]  acc_size_s;
   logic [31:0] acc_addr_s, acc_wdata_s;
   logic [AW-1:0] word_idx_s;
   logic [31:0] rword_s, ld_rdata_s, wdata_lane_s;
   logic [3:0]  byte_en_s;

   assign accept_s = req_valid & (state_r == IDLE);

   // Next-state and wait-counter logic
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (req_valid) begin
               if (LATENCY == 0) begin
                  state_nx_s = RESP;
                  cnt_nx_s   = 3'd0;
               end else begin
                  state_nx_s = WAIT;
                  cnt_nx_s   = CNT_INIT;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == 3'd0) begin
               state_nx_s = RESP;
            end else begin
               cnt_nx_s = cnt_r - 3'd1;
            end
         end
         RESP: begin
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
            cnt_nx_s   = 3'd0;
         end
      endcase
   end

   // With LATENCY=0 the access happens on the accept edge itself, so the
   // live request fields are used while still in IDLE.
   always_comb begin
      if (state_r == IDLE) begin
         acc_write_s    = req_write;
         acc_size_s     = req_size;
         acc_unsigned_s = req_unsigned;
         acc_addr_s     = req_addr;
         acc_wdata_s    = req_wdata;
      end else begin
         acc_write_s    = write_r;
         acc_size_s     = size_r;
         acc_unsigned_s = unsigned_r;
         acc_addr_s     = addr_r;
         acc_wdata_s    = wdata_r;
      end
   end

   // Gated by reset so a request held during reset never touches memory.
   assign enter_resp_s = reset & (state_nx_s == RESP) & (state_r != RESP);
   assign word_idx_s   = acc_addr_s[2 +: AW];
   assign err_s        = misaligned(acc_size_s, acc_addr_s[1:0]) | (|acc_addr_s[31:AW+2]);
   assign mem_we_s     = enter_resp_s & acc_write_s & ~err_s;
   assign rword_s      = memory[word_idx_s];

   lsu_lane_align u_lane_align (
      .size        (acc_size_s),
      .is_unsigned (acc_unsigned_s),
      .lane        (acc_addr_s[1:0]),
      .rword       (rword_s),
      .wdata       (acc_wdata_s),
      .rdata       (ld_rdata_s),
      .byte_en     (byte_en_s),
      .wdata_lane  (wdata_lane_s)
   );

   // Byte-enabled store into the data array; contents survive reset
   always_ff @(posedge clock) begin
      if (mem_we_s) begin
         for (int b = 0; b < 4; b++) begin
            if (byte_en_s[b]) begin
               memory[word_idx_s][8*b +: 8] <= wdata_lane_s[8*b +: 8];
            end
         end
      end
   end

   // State, counter, request latch and registered response
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         cnt_r        <= 3'd0;
         write_r      <= 1'b0;
         size_r       <= 2'd0;
         unsigned_r   <= 1'b0;
         addr_r       <= 32'd0;
         wdata_r      <= 32'd0;
         resp_rdata_r <= 32'd0;
         resp_error_r <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         if (accept_s) begin
            write_r    <= req_write;
            size_r     <= req_size;
            unsigned_r <= req_unsigned;
            addr_r     <= req_addr;
            wdata_r    <= req_wdata;
         end
         if (enter_resp_s) begin
            resp_error_r <= err_s;
            resp_rdata_r <= (err_s | acc_write_s) ? 32'd0 : ld_rdata_s;
         end else begin
            resp_error_r <= 1'b0;
            resp_rdata_r <= 32'd0;
         end
      end
   end

   assign req_ready  = (state_r == IDLE);
   assign resp_valid = (state_r == RESP);
   assign resp_rdata = resp_rdata_r;
   assign resp_error = resp_error_r;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words in the data array (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 1, number of wait cycles between accept and access (0..7).
REQ-003 SHALL have the port clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have the port req_valid, input, 1 bit: request present.
REQ-006 SHALL have the port req_ready, output, 1 bit: unit can accept a request.
REQ-007 SHALL have the port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have the port req_size, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 SHALL have the port req_unsigned, input, 1 bit: zero-extend loads (lbu/lhu) when 1, sign-extend when 0.
REQ-010 SHALL have the port req_addr, input, 32 bits: byte address.
REQ-011 SHALL have the port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 SHALL have the port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have the port resp_rdata, output, 32 bits: extended load data.
REQ-014 SHALL have the port resp_error, output, 1 bit: request rejected.

Function
REQ-015 SHALL hold storage in an internal array named memory, DEPTH x 32 bits, little-endian, so $readmemh/$writememh can address it hierarchically.
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, latching write, size, unsigned, address and wdata.
REQ-018 SHALL go from IDLE to WAIT on accept when LATENCY>0 and load the wait counter with LATENCY-1; go directly to RESP when LATENCY=0.
REQ-019 SHALL decrement the counter in WAIT and go to RESP when it is 0.
REQ-020 SHALL perform the memory read or write on the edge entering RESP; resp_valid=1 for exactly the RESP cycle, then return to IDLE; accept-to-resp_valid latency = LATENCY+1 cycles.
REQ-021 SHALL compute the word index as addr[2 +: log2(DEPTH)] and the byte lane as addr[1:0].
REQ-022 SHALL flag an error for half with addr[0]=1, word with addr[1:0]!=0, size=3, or addr >= 4*DEPTH; on error, memory is unchanged, resp_error=1 and resp_rdata=0.
REQ-023 SHALL on loads, extract the addressed byte/half and sign- or zero-extend it per the latched unsigned flag; word loads return the word unchanged.
REQ-024 SHALL on stores, modify only the addressed bytes: the byte store writes wdata[7:0], the half store writes wdata[15:0], the word store writes all 4 bytes.
REQ-025 SHALL hold resp_rdata and resp_error at 0 outside RESP.
REQ-026 SHALL ignore req_valid and all request inputs outside IDLE (no buffering); back-to-back requests give one transaction per LATENCY+2 cycles.
REQ-027 SHALL return, for a store, resp_rdata=0 in RESP.

Reset
REQ-028 SHALL, while reset=0, force state IDLE, counter 0, req_ready=1, resp_valid=0, resp_rdata=0 and resp_error=0, independent of clock.
REQ-029 SHALL NOT clear memory contents on reset.
REQ-030 SHALL discard a transaction interrupted by reset before RESP: no memory write and no response.

Structure
REQ-031 SHALL place the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the FSM state encoding in shared package lsu_pkg.
REQ-032 SHALL put lane extract/extend and byte-enable generation in a combinational sub-module lsu_lane_align, instantiated once.

Verification
REQ-033 SHALL cover: LATENCY=1, preload memory[2]=0x8001_7F80, lb addr 8 -> resp_rdata=0xFFFF_FF80 exactly 2 cycles after accept; lbu addr 8 -> 0x0000_0080; lh addr 10 -> 0xFFFF_8001.
REQ-034 SHALL cover: sb 0xAB to addr 13 over memory[3]=0x1122_3344 -> memory[3]=0x1122_AB44; sh 0xBEEF to addr 14 -> 0xBEEF_AB44.
REQ-035 SHALL cover: lw addr 6 and sh addr 5 -> resp_error=1, resp_rdata=0, memory unchanged; lw addr 4*DEPTH -> resp_error=1.
REQ-036 SHALL cover: LATENCY=0 and LATENCY=7 builds with sw then lw of the same address -> readback equal, response at accept+1 and accept+8 cycles, req_ready=0 throughout.
REQ-037 SHALL cover: sw 0xDEAD_BEEF accepted, reset=0 asserted in WAIT -> no resp_valid, memory unchanged, req_ready=1 immediately after reset deassertion.
